// File: rtl/hm_mrd_tx.sv
// hm_mrd_tx: host-memory read request transmitter.
// Builds one PCIe Memory Read TLP per hm_start on the 64-bit TRN transmit
// interface, then waits for the receive stage to report completion or for
// a timeout. Optional build macro HM_MRD_TX_4DW_EN enables 4DW headers for
// addresses at or above 4 GB; without it every request is 3DW.
module hm_mrd_tx #(
    parameter logic [31:0] TIMEOUT = 32'd65535
) (
    input  logic        trn_clk,
    input  logic        sys_rst,
    input  logic        hm_start,
    input  logic [63:0] hm_addr,
    input  logic [9:0]  hm_len,
    input  logic [15:0] cfg_completer_id,
    input  logic        rx_memory_read,
    output logic        hm_busy,
    output logic        hm_done,
    output logic        hm_err,
    output logic [63:0] trn_td,
    output logic        trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    output logic        trn_tsrc_dsc_n,
    input  logic        trn_tdst_rdy_n,
    input  logic        trn_tdst_dsc_n,
    input  logic        trn_lnk_up_n,
    input  logic [5:0]  trn_tbuf_av,
    output logic [31:0] stat_trn_cpt_tx,
    output logic [1:0]  stat_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR0 = 2'd1,
        HDR1 = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:2] addr_lo_q, addr_lo_d;
    logic        is4_q, is4_d;
    logic [31:0] addr_hi_q, addr_hi_d;
    logic [7:0]  tag_q, tag_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] stat_d;
    logic        done_d, err_d;
    logic [63:0] td_d;
    logic        tsof_n_d, teof_n_d, tsrc_rdy_n_d, trem_n_d;

    // Request decode from the inputs presented with hm_start.
    logic        start_ok;
    logic        start_is4;
    logic [10:0] start_len_eff;
    logic [11:0] start_end_dw;
    logic        start_cross;
    logic [3:0]  start_last_be;
    logic [63:0] hdr0_beat;
    logic [63:0] hdr1_beat;
    logic        beat_accept;
    logic        link_abort;
    logic        timeout_hit;

`ifdef HM_MRD_TX_4DW_EN
    assign start_is4 = (hm_addr[63:32] != 32'h0);
`else
    assign start_is4 = 1'b0;
`endif

    assign start_ok      = hm_start && !trn_lnk_up_n && (trn_tbuf_av != 6'd0);
    assign start_len_eff = (hm_len == 10'd0) ? 11'd1024 : {1'b0, hm_len};
    assign start_end_dw  = {2'b00, hm_addr[11:2]} + {1'b0, start_len_eff};
    assign start_cross   = (start_end_dw > 12'd1024);
    assign start_last_be = (start_len_eff > 11'd1) ? 4'hF : 4'h0;

    assign hdr0_beat = {1'b0, start_is4 ? 2'b01 : 2'b00, 5'b00000, 1'b0, 3'b000,
                        4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, hm_len,
                        cfg_completer_id, tag_q, start_last_be, 4'hF};

    assign hdr1_beat = is4_q ? {addr_hi_q, addr_lo_q, 2'b00}
                             : {addr_lo_q, 2'b00, 32'h0000_0000};

    assign beat_accept = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
    assign link_abort  = trn_lnk_up_n || !trn_tdst_dsc_n;
    assign timeout_hit = ({1'b0, cnt_q} + 33'd1) >= {1'b0, TIMEOUT};

    assign hm_busy        = (state_q != IDLE);
    assign stat_state     = state_q;
    assign trn_tsrc_dsc_n = 1'b1;

    // Next-state and next-output decode; every TRN output is registered.
    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        addr_hi_d    = addr_hi_q;
        is4_d        = is4_q;
        tag_d        = tag_q;
        cnt_d        = cnt_q;
        stat_d       = stat_trn_cpt_tx;
        done_d       = 1'b0;
        err_d        = 1'b0;
        td_d         = trn_td;
        tsof_n_d     = trn_tsof_n;
        teof_n_d     = trn_teof_n;
        tsrc_rdy_n_d = trn_tsrc_rdy_n;
        trem_n_d     = trn_trem_n;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (start_cross) begin
                        err_d = 1'b1;
                    end else begin
                        state_d      = HDR0;
                        addr_lo_d    = hm_addr[31:2];
`ifdef HM_MRD_TX_4DW_EN
                        addr_hi_d    = hm_addr[63:32];
`endif
                        is4_d        = start_is4;
                        td_d         = hdr0_beat;
                        tsof_n_d     = 1'b0;
                        teof_n_d     = 1'b1;
                        tsrc_rdy_n_d = 1'b0;
                        trem_n_d     = 1'b0;
                    end
                end
            end
            HDR0: begin
                if (link_abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (beat_accept) begin
                    state_d  = HDR1;
                    td_d     = hdr1_beat;
                    tsof_n_d = 1'b1;
                    teof_n_d = 1'b0;
                    trem_n_d = !is4_q;
                end
            end
            HDR1: begin
                if (link_abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (beat_accept) begin
                    state_d = WAIT;
                    stat_d  = stat_trn_cpt_tx + 32'd1;
                    tag_d   = tag_q + 8'd1;
                    cnt_d   = 32'd0;
                end
            end
            WAIT: begin
                if (trn_lnk_up_n) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (rx_memory_read) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Any transition into IDLE or WAIT leaves the TRN bus quiet.
        if (state_d == IDLE || state_d == WAIT) begin
            td_d         = 64'h0;
            tsof_n_d     = 1'b1;
            teof_n_d     = 1'b1;
            tsrc_rdy_n_d = 1'b1;
            trem_n_d     = 1'b1;
        end
    end

    // State, bookkeeping and registered outputs with synchronous reset.
    always_ff @(posedge trn_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (sys_rst) begin
            state_q         <= IDLE;
            addr_lo_q       <= '0;
            addr_hi_q       <= '0;
            is4_q           <= 1'b0;
            tag_q           <= 8'd0;
            cnt_q           <= 32'd0;
            stat_trn_cpt_tx <= 32'd0;
            hm_done         <= 1'b0;
            hm_err          <= 1'b0;
            trn_td          <= 64'h0;
            trn_tsof_n      <= 1'b1;
            trn_teof_n      <= 1'b1;
            trn_tsrc_rdy_n  <= 1'b1;
            trn_trem_n      <= 1'b1;
        end else begin
            state_q         <= state_d;
            addr_lo_q       <= addr_lo_d;
            addr_hi_q       <= addr_hi_d;
            is4_q           <= is4_d;
            tag_q           <= tag_d;
            cnt_q           <= cnt_d;
            stat_trn_cpt_tx <= stat_d;
            hm_done         <= done_d;
            hm_err          <= err_d;
            trn_td          <= td_d;
            trn_tsof_n      <= tsof_n_d;
            trn_teof_n      <= teof_n_d;
            trn_tsrc_rdy_n  <= tsrc_rdy_n_d;
            trn_trem_n      <= trem_n_d;
        end
    end

endmodule

// File: tb/tb_hm_mrd_tx.sv
// Self-checking bench for hm_mrd_tx: directed cases plus randomized requests
// checked against a transaction-level model of the read-request rules.
module tb_hm_mrd_tx;

    localparam int TO = 16;

    logic        trn_clk = 1'b0;
    logic        sys_rst;
    logic        hm_start;
    logic [63:0] hm_addr;
    logic [9:0]  hm_len;
    logic [15:0] cfg_completer_id;
    logic        rx_memory_read;
    logic        hm_busy, hm_done, hm_err;
    logic [63:0] trn_td;
    logic        trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
    logic        trn_tdst_rdy_n, trn_tdst_dsc_n, trn_lnk_up_n;
    logic [5:0]  trn_tbuf_av;
    logic [31:0] stat_trn_cpt_tx;
    logic [1:0]  stat_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  m_tag;
    logic [31:0] m_stat;

    always #5 trn_clk = ~trn_clk;

    hm_mrd_tx #(.TIMEOUT(32'd16)) dut (
        .trn_clk(trn_clk), .sys_rst(sys_rst), .hm_start(hm_start),
        .hm_addr(hm_addr), .hm_len(hm_len), .cfg_completer_id(cfg_completer_id),
        .rx_memory_read(rx_memory_read), .hm_busy(hm_busy), .hm_done(hm_done),
        .hm_err(hm_err), .trn_td(trn_td), .trn_trem_n(trn_trem_n),
        .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
        .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n),
        .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tdst_dsc_n(trn_tdst_dsc_n),
        .trn_lnk_up_n(trn_lnk_up_n), .trn_tbuf_av(trn_tbuf_av),
        .stat_trn_cpt_tx(stat_trn_cpt_tx), .stat_state(stat_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge trn_clk);
        #1;
    endtask

    // Reference rules, written from the request format rather than the RTL.
    function automatic bit model_is4(input logic [63:0] a);
`ifdef HM_MRD_TX_4DW_EN
        return a[63:32] != 32'h0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int eff_len(input logic [9:0] l);
        return (l == 10'd0) ? 1024 : int'(l);
    endfunction

    function automatic bit crosses(input logic [63:0] a, input logic [9:0] l);
        int offs;
        offs = int'(a[11:0]) / 4;
        return (offs + eff_len(l)) > 1024;
    endfunction

    function automatic logic [63:0] exp_hdr0(input logic [63:0] a, input logic [9:0] l,
                                             input logic [7:0] tag);
        logic [31:0] up, lo;
        up = (model_is4(a) ? 32'h2000_0000 : 32'h0) + 32'(l);
        lo = 32'(cfg_completer_id) * 32'd65536 + 32'(tag) * 32'd256
             + ((eff_len(l) > 1) ? 32'hF0 : 32'h0) + 32'hF;
        return {up, lo};
    endfunction

    function automatic logic [63:0] exp_hdr1(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0] & 32'hFFFF_FFFC;
        if (model_is4(a)) return {a[63:32], lo};
        return {lo, 32'h0};
    endfunction

    task automatic check_reset_values(input string pfx);
        check({pfx, "_td"}, trn_td, 64'h0);
        check({pfx, "_sof"}, trn_tsof_n, 1'b1);
        check({pfx, "_eof"}, trn_teof_n, 1'b1);
        check({pfx, "_rdy"}, trn_tsrc_rdy_n, 1'b1);
        check({pfx, "_rem"}, trn_trem_n, 1'b1);
        check({pfx, "_dsc"}, trn_tsrc_dsc_n, 1'b1);
        check({pfx, "_busy"}, hm_busy, 1'b0);
        check({pfx, "_done"}, hm_done, 1'b0);
        check({pfx, "_err"}, hm_err, 1'b0);
        check({pfx, "_stat"}, stat_trn_cpt_tx, 32'd0);
        check({pfx, "_state"}, stat_state, 2'd0);
    endtask

    // mode: 0 rx after dly, 1 timeout, 2 rx on expiry, 3 discontinue in HDR1,
    //       4 reset mid-WAIT
    task automatic run_req(input logic [63:0] a, input logic [9:0] l, input int st0,
                           input int st1, input int mode, input int dly);
        logic [63:0] h0, h1;
        bit          is4;
        is4 = model_is4(a);
        h0  = exp_hdr0(a, l, m_tag);
        h1  = exp_hdr1(a);
        hm_addr = a; hm_len = l; hm_start = 1'b1; trn_tdst_rdy_n = 1'b1;
        tick();
        hm_start = 1'b0;
        check("done_pulse_end", hm_done, 1'b0);
        if (crosses(a, l)) begin
            check("xing_err", hm_err, 1'b1);
            check("xing_busy", hm_busy, 1'b0);
            check("xing_no_tlp", trn_tsrc_rdy_n, 1'b1);
            tick();
            check("xing_err_pulse", hm_err, 1'b0);
            return;
        end
        check("hdr0_busy", hm_busy, 1'b1);
        for (int s = 0; s <= st0; s++) begin
            trn_tdst_rdy_n = (s < st0);
            check("hdr0_td", trn_td, h0);
            check("hdr0_sof", trn_tsof_n, 1'b0);
            check("hdr0_eof", trn_teof_n, 1'b1);
            check("hdr0_rem", trn_trem_n, 1'b0);
            check("hdr0_rdy", trn_tsrc_rdy_n, 1'b0);
            tick();
        end
        if (mode == 3) begin
            trn_tdst_rdy_n = 1'b1;
            trn_tdst_dsc_n = 1'b0;
            check("dsc_hdr1_td", trn_td, h1);
            tick();
            trn_tdst_dsc_n = 1'b1;
            check("dsc_err", hm_err, 1'b1);
            check("dsc_rdy", trn_tsrc_rdy_n, 1'b1);
            check("dsc_state", stat_state, 2'd0);
            check("dsc_stat", stat_trn_cpt_tx, m_stat);
            tick();
            check("dsc_err_pulse", hm_err, 1'b0);
            return;
        end
        for (int s = 0; s <= st1; s++) begin
            trn_tdst_rdy_n = (s < st1);
            check("hdr1_td", trn_td, h1);
            check("hdr1_sof", trn_tsof_n, 1'b1);
            check("hdr1_eof", trn_teof_n, 1'b0);
            check("hdr1_rem", trn_trem_n, is4 ? 1'b0 : 1'b1);
            check("hdr1_rdy", trn_tsrc_rdy_n, 1'b0);
            tick();
        end
        trn_tdst_rdy_n = 1'b1;
        m_stat = m_stat + 32'd1;
        m_tag  = m_tag + 8'd1;
        check("wait_state", stat_state, 2'd3);
        check("wait_rdy", trn_tsrc_rdy_n, 1'b1);
        check("wait_stat", stat_trn_cpt_tx, m_stat);
        case (mode)
            0: begin
                for (int k = 0; k < dly; k++) begin
                    hm_start = (k == 0);
                    tick();
                    hm_start = 1'b0;
                    check("wait_hold", stat_state, 2'd3);
                    check("wait_nodone", hm_done, 1'b0);
                end
                rx_memory_read = 1'b1;
                tick();
                rx_memory_read = 1'b0;
                check("done", hm_done, 1'b1);
                check("done_noerr", hm_err, 1'b0);
                check("done_busy", hm_busy, 1'b0);
            end
            1: begin
                for (int k = 1; k <= TO; k++) begin
                    tick();
                    check("to_err", hm_err, k == TO);
                    check("to_done", hm_done, 1'b0);
                end
                check("to_state", stat_state, 2'd0);
            end
            2: begin
                for (int k = 1; k <= TO; k++) begin
                    rx_memory_read = (k == TO);
                    tick();
                    check("exp_done", hm_done, k == TO);
                    check("exp_err", hm_err, 1'b0);
                end
                rx_memory_read = 1'b0;
            end
            default: begin
                tick();
                tick();
                sys_rst = 1'b1;
                tick();
                sys_rst = 1'b0;
                check_reset_values("rst_wait");
                m_stat = 32'd0;
                m_tag  = 8'd0;
            end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra;
        logic [9:0]  rl;
        int          rm;
        sys_rst = 1'b1; hm_start = 1'b0; hm_addr = '0; hm_len = '0;
        cfg_completer_id = 16'h0100; rx_memory_read = 1'b0;
        trn_tdst_rdy_n = 1'b1; trn_tdst_dsc_n = 1'b1; trn_lnk_up_n = 1'b0;
        trn_tbuf_av = 6'd8;
        m_tag = 8'd0; m_stat = 32'd0;
        tick();
        tick();
        sys_rst = 1'b0;
        check_reset_values("reset");

        run_req(64'h0000_0000_0000_1000, 10'd4, 0, 0, 0, 2);
        check("first_tag_stat", stat_trn_cpt_tx, 32'd1);
        run_req(64'h0000_0000_0000_2000, 10'd1, 0, 0, 0, 0);
        run_req(64'h0000_0000_0000_3000, 10'd0, 0, 0, 0, 1);
        run_req(64'h0000_0000_0000_0400, 10'd8, 3, 3, 0, 0);
        run_req(64'h0000_0001_0000_0040, 10'd2, 0, 1, 0, 0);
        run_req(64'h0000_0000_0000_0100, 10'd4, 0, 0, 1, 0);
        run_req(64'h0000_0000_0000_0200, 10'd4, 1, 0, 2, 0);
        run_req(64'h0000_0000_0000_0FF8, 10'd4, 0, 0, 0, 0);
        run_req(64'h0000_0000_0000_0500, 10'd4, 0, 0, 3, 0);

        // Starts that must be dropped, and rx_memory_read while idle.
        trn_lnk_up_n = 1'b1; hm_start = 1'b1; tick(); hm_start = 1'b0;
        check("drop_lnk_state", stat_state, 2'd0);
        check("drop_lnk_err", hm_err, 1'b0);
        trn_lnk_up_n = 1'b0; trn_tbuf_av = 6'd0; hm_start = 1'b1; tick(); hm_start = 1'b0;
        check("drop_buf_state", stat_state, 2'd0);
        trn_tbuf_av = 6'd8; rx_memory_read = 1'b1; tick(); rx_memory_read = 1'b0;
        check("idle_rx_ignored", hm_done, 1'b0);

        for (int i = 0; i < 25; i++) begin
            ra = {($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'h0, 32'($urandom)};
            if ($urandom_range(0, 1) == 1) ra[11:0] = 12'($urandom_range(0, 63) * 4);
            rl = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(0, 1))
                                             : 10'($urandom_range(2, 512));
            cfg_completer_id = 16'($urandom);
            rm = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            run_req(ra, rl, $urandom_range(0, 3), $urandom_range(0, 3), rm,
                    $urandom_range(0, 5));
        end

        run_req(64'h0000_0000_0000_0600, 10'd16, 0, 0, 4, 0);
        run_req(64'h0000_0000_0000_0700, 10'd3, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hm_mrd_tx.md
# hm_mrd_tx

Transmit stage of the host-memory read path. On a start pulse it builds and sends one PCIe Memory Read request TLP (3 or 4 DW header) on the Virtex-6 64-bit TRN transmit interface. It then waits for the downstream receive stage to report that all completion data has been written (`rx_memory_read`), or for a timeout. It sits directly upstream of the completion receiver and shares its clock and statistics style.

## Interface
Parameters:
- `TIMEOUT`, default 32'd65535: `trn_clk` cycles to wait in WAIT before declaring timeout.

Ports:
- `trn_clk`  in  1  sole clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `hm_start`  in  1  one-cycle request pulse; sampled only in IDLE.
- `hm_addr`  in  64  byte address; bits [1:0] ignored (DW aligned).
- `hm_len`  in  10  length in DW; 0 encodes 1024.
- `cfg_completer_id`  in  16  bus/dev/func used as requester ID.
- `rx_memory_read`  in  1  pulse from the receive stage: last completion consumed.
- `hm_busy`  out  1  high in any state other than IDLE.
- `hm_done`  out  1  one-cycle pulse on successful completion.
- `hm_err`  out  1  one-cycle pulse on timeout, discontinue, link loss, or 4 KB crossing.
- `trn_td`  out  64  TLP data; first DW in [63:32].
- `trn_trem_n`  out  1  0: both DWs valid; 1: only [63:32] valid.
- `trn_tsof_n`, `trn_teof_n`, `trn_tsrc_rdy_n`, `trn_tsrc_dsc_n`  out  1 each.
- `trn_tdst_rdy_n`, `trn_tdst_dsc_n`, `trn_lnk_up_n`  in  1 each.
- `trn_tbuf_av`  in  6  core transmit buffer availability.
- `stat_trn_cpt_tx`  out  32  count of TLPs fully accepted by the core.
- `stat_state`  out  2  current state encoding.

## Operation
- States (2-bit): IDLE=0, HDR0=1, HDR1=2, WAIT=3.
- Beat acceptance: `trn_tsrc_rdy_n==0 && trn_tdst_rdy_n==0`.
- IDLE → HDR0 on `hm_start` when `trn_lnk_up_n==0` and `trn_tbuf_av!=0`. Latch addr, len, and tag.
  - If the request would cross a 4 KB boundary (`addr[11:2] + len > 1024`), pulse `hm_err`, stay IDLE, and send no TLP.
  - `hm_start` when any of these conditions fails, or when busy, is dropped.
- HDR0 beat:
  - [63:32] = {1'b0, fmt, 5'b00000, 1'b0, 3'b000, 4'b0, 1'b0, 1'b0, 2'b00, 2'b00, len}. fmt = 2'b00 for 3DW, 2'b01 for 4DW.
  - [31:0] = {cfg_completer_id, tag, lastBE, 4'hF}. lastBE = 4'hF if length > 1 DW, else 4'h0.
  - `tsof_n=0`, `trem_n=0`. On accept → HDR1.
- HDR1 beat:
  - 3DW: {addr[31:2], 2'b00, 32'b0}, `trem_n=1`.
  - 4DW: {addr[63:32], addr[31:2], 2'b00}, `trem_n=0`.
  - `teof_n=0`. On accept: `stat_trn_cpt_tx+1`, tag+1 (8-bit wrap), timeout counter cleared → WAIT.
- WAIT:
  - `rx_memory_read` → pulse `hm_done`, go IDLE.
  - Counter reaching `TIMEOUT` → pulse `hm_err`, go IDLE.
  - If both occur in the same cycle, done wins.
- `rx_memory_read` outside WAIT is ignored.
- `trn_tdst_dsc_n==0` in HDR0/HDR1: drop `tsrc_rdy_n`, pulse `hm_err`, go IDLE, no stat increment.
- `trn_lnk_up_n==1` in any non-IDLE state: same as discontinue.
- `trn_tsrc_dsc_n` is tied to 1.

## Timing
- Reset values:
  - state IDLE, tag 0, `stat_trn_cpt_tx` 0.
  - `hm_busy`/`hm_done`/`hm_err` = 0.
  - `trn_tsof_n`/`trn_teof_n`/`trn_tsrc_rdy_n`/`trn_trem_n` = 1, `trn_td` = 0.
- Reset mid-TLP aborts immediately. No EOF is emitted; the core discards the partial TLP.
- `hm_start` at cycle N → HDR0 valid at N+1. Minimum TLP duration is 2 cycles; each back-pressure cycle adds one.
- All TRN outputs are registered and held stable while `trn_tdst_rdy_n==1`.
- `hm_done` is asserted the cycle after `rx_memory_read` is sampled.
- Earliest restart after `hm_done`: `hm_start` is accepted the following cycle.

## Configuration
- `HM_MRD_TX_4DW_EN` defined:
  - `addr[63:32]!=0` selects a 4DW header (fmt 01).
  - `addr[63:32]==0` uses 3DW (the spec requires 3DW below 4 GB).
- Not defined:
  - `hm_addr[63:32]` is ignored and every request is 3DW.
  - HDR1 is always the 3DW format.

## Test plan
- Idle core, addr=0x0000_1000, len=4, id=0x0100 → HDR0 = 0x00000004_0100_00FF, HDR1 = 0x00001000_xxxxxxxx with trem_n=1. Then `rx_memory_read` → `hm_done` 1 cycle later, stat=1, tag=1.
- len=1 → lastBE=0. len=0 → length field 0, request 1024 DW at a 4 KB-aligned address.
- `trn_tdst_rdy_n` high for 3 cycles on each beat → beats held stable, TLP completes in 8 cycles.
- With `HM_MRD_TX_4DW_EN`: addr=0x1_0000_0040 → fmt=01, HDR1 = 0x00000001_00000040, trem_n=0. Without the macro → 3DW with addr 0x40.
- No `rx_memory_read` → `hm_err` exactly `TIMEOUT` cycles after HDR1 accept. Override `TIMEOUT=16`, and fire `rx_memory_read` on the expiry cycle → `hm_done` only.
- Error cases:
  - addr=0xFF8, len=4 → `hm_err`, no TLP.
  - `trn_tdst_dsc_n` low in HDR1 → abort, `hm_err`, stat unchanged.
  - `sys_rst` mid-WAIT → all outputs at reset values next cycle.
